// File: rtl/mult_div_unit_if.sv
// ---------------------------------------------------------------------------
// mult_div_unit_if
//   Bundles the EX-stage connection to the iterative multiply/divide unit.
//   master : pipeline side (launch, flush, MTHI/MTLO writes; sees HI/LO/status)
//   slave  : unit side
//   Signals
//     start_i  launch op_i on rs_i/rt_i      op_i    00 MULT 01 MULTU 10 DIV 11 DIVU
//     rs_i     operand A                     rt_i    operand B
//     flush_i  abort in-flight operation     hi_we_i / lo_we_i  MTHI / MTLO
//     wdata_i  MTHI/MTLO data                busy_o  operation in flight
//     done_o   one-cycle result pulse        hi_o / lo_o  HI / LO registers
// ---------------------------------------------------------------------------
interface mult_div_unit_if #(
    parameter int DATA_W = 32
);
    logic              start_i;
    logic [1:0]        op_i;
    logic [DATA_W-1:0] rs_i;
    logic [DATA_W-1:0] rt_i;
    logic              flush_i;
    logic              hi_we_i;
    logic              lo_we_i;
    logic [DATA_W-1:0] wdata_i;
    logic              busy_o;
    logic              done_o;
    logic [DATA_W-1:0] hi_o;
    logic [DATA_W-1:0] lo_o;

    modport master (
        output start_i, op_i, rs_i, rt_i, flush_i, hi_we_i, lo_we_i, wdata_i,
        input  busy_o, done_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, op_i, rs_i, rt_i, flush_i, hi_we_i, lo_we_i, wdata_i,
        output busy_o, done_o, hi_o, lo_o
    );
endinterface

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//   Iterative DATA_W-bit multiply/divide unit with HI/LO registers.
//   Operations work on operand magnitudes: one shift-add (multiply) or one
//   restoring shift-subtract (divide) step per cycle for DATA_W cycles, then a
//   single FIX cycle applies sign correction and writes HI/LO.
//   Ports
//     clk_i  clock, all state updates on posedge
//     rst_i  asynchronous active-low reset
//     bus    mult_div_unit_if.slave (launch/flush/MT writes in, HI/LO/status out)
// ---------------------------------------------------------------------------
module mult_div_unit #(
    parameter int DATA_W = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    mult_div_unit_if.slave  bus
);
    localparam int                CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q;
    logic              is_div_q;
    logic              neg_prod_q;   // MULT: product must be negated
    logic              neg_quo_q;    // DIV: quotient must be negated
    logic              neg_rem_q;    // DIV: remainder takes dividend sign
    logic              div_zero_q;
    logic [DATA_W-1:0] a_raw_q;      // original dividend, returned in HI on /0
    logic [DATA_W-1:0] b_mag_q;      // multiplicand / divisor magnitude
    logic [DATA_W-1:0] p_hi_q;       // product high half / partial remainder
    logic [DATA_W-1:0] p_lo_q;       // multiplier bits / dividend -> quotient
    logic [DATA_W-1:0] hi_q, lo_q;

    // ---------------- operand decode (sampled only on launch) --------------
    logic              op_signed;
    logic              a_neg, b_neg;
    logic [DATA_W-1:0] a_mag, b_mag;
    logic              launch;

    assign op_signed = ~bus.op_i[0];
    assign a_neg     = op_signed & bus.rs_i[DATA_W-1];
    assign b_neg     = op_signed & bus.rt_i[DATA_W-1];
    // Magnitude of the most negative value wraps to itself, which reads back
    // correctly as 2^(DATA_W-1) when treated as unsigned.
    assign a_mag     = a_neg ? -bus.rs_i : bus.rs_i;
    assign b_mag     = b_neg ? -bus.rt_i : bus.rt_i;
    assign launch    = (state_q == S_IDLE) && bus.start_i && !bus.flush_i;

    // ---------------- FSM ---------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        // NOTE: sequential state uses non-blocking (<=) so every register
        // samples pre-edge values regardless of block ordering.
        if (!rst_i) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        // NOTE: default assigned first so no path leaves state_d unassigned,
        // which would otherwise infer a latch.
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (launch) state_d = S_CALC;
            S_CALC: begin
                if (bus.flush_i)              state_d = S_IDLE;
                else if (count_q == LAST_CNT) state_d = S_FIX;
            end
            S_FIX:  state_d = bus.flush_i ? S_IDLE : S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- single iteration step --------------------------------
    logic [DATA_W:0]   mul_sum;
    logic [DATA_W:0]   div_shift;
    logic [DATA_W:0]   div_trial;
    logic              div_ge;

    assign mul_sum   = {1'b0, p_hi_q} + (p_lo_q[0] ? {1'b0, b_mag_q} : '0);
    assign div_shift = {p_hi_q, p_lo_q[DATA_W-1]};
    // Compare on the full DATA_W+1 bits: the shifted remainder may exceed
    // DATA_W bits, in which case it is always >= the divisor.
    assign div_ge    = div_shift >= {1'b0, b_mag_q};
    assign div_trial = div_shift - {1'b0, b_mag_q};

    // ---------------- sign correction / special cases ----------------------
    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   quo_fix, rem_fix;
    logic [DATA_W-1:0]   res_hi, res_lo;

    always_comb begin
        prod_fix = neg_prod_q ? -{p_hi_q, p_lo_q} : {p_hi_q, p_lo_q};
        quo_fix  = neg_quo_q ? -p_lo_q : p_lo_q;
        rem_fix  = neg_rem_q ? -p_hi_q : p_hi_q;
        res_hi   = prod_fix[2*DATA_W-1:DATA_W];
        res_lo   = prod_fix[DATA_W-1:0];
        if (is_div_q) begin
            if (div_zero_q) begin
                res_hi = a_raw_q;
                res_lo = '1;
            end else begin
                res_hi = rem_fix;
                res_lo = quo_fix;
            end
        end
    end

    // ---------------- datapath ---------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count_q    <= '0;
            is_div_q   <= 1'b0;
            neg_prod_q <= 1'b0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            a_raw_q    <= '0;
            b_mag_q    <= '0;
            p_hi_q     <= '0;
            p_lo_q     <= '0;
        end else if (launch) begin
            count_q    <= '0;
            is_div_q   <= bus.op_i[1];
            neg_prod_q <= a_neg ^ b_neg;
            neg_quo_q  <= a_neg ^ b_neg;
            neg_rem_q  <= a_neg;
            div_zero_q <= (bus.rt_i == '0);
            a_raw_q    <= bus.rs_i;
            b_mag_q    <= b_mag;
            p_hi_q     <= '0;
            p_lo_q     <= a_mag;
        end else if (state_q == S_CALC) begin
            count_q <= count_q + CNT_W'(1);
            if (is_div_q) begin
                p_hi_q <= div_ge ? div_trial[DATA_W-1:0] : div_shift[DATA_W-1:0];
                p_lo_q <= {p_lo_q[DATA_W-2:0], div_ge};
            end else begin
                // Add-then-shift-right: product accumulates in p_hi while the
                // consumed multiplier bits shift out of p_lo.
                p_hi_q <= mul_sum[DATA_W:1];
                p_lo_q <= {mul_sum[0], p_lo_q[DATA_W-1:1]};
            end
        end
    end

    // ---------------- HI / LO ----------------------------------------------
    logic mt_ok;
    assign mt_ok = (state_q == S_IDLE) || (state_q == S_DONE);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (state_q == S_FIX) begin
            if (!bus.flush_i) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end
        end else if (mt_ok) begin
            if (bus.hi_we_i) hi_q <= bus.wdata_i;
            if (bus.lo_we_i) lo_q <= bus.wdata_i;
        end
    end

    assign bus.busy_o = (state_q == S_CALC) || (state_q == S_FIX);
    assign bus.done_o = (state_q == S_DONE);
    assign bus.hi_o   = hi_q;
    assign bus.lo_o   = lo_q;

endmodule
